spi_regbank: RTL

//  Parametrised SPI (mode 0) slave register bank. Successor to the fixed 5-register write-only peripheral.

---
 rtl/spi_regbank.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_regbank.sv
// SPI mode-0 slave register bank: synchronised pins, frame FSM, write commit on nCS release,
// shadow-register read-back on CIPO and rejection of short or overlong frames.
module spi_regbank #(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_FULL = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    function automatic logic [NUM_REGS-1:0] addr_sel(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] sel;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (a == ADDR_W'(k)) begin
                sel[k] = 1'b1;
            end else begin
                sel[k] = 1'b0;
            end
        end
        return sel;
    endfunction

    // Out-of-range addresses select nothing, so they read back as zero.
    function automatic logic [DATA_W-1:0] read_mux(input logic [NUM_REGS*DATA_W-1:0] r,
                                                   input logic [NUM_REGS-1:0]        sel);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel[k]) begin
                v = v | r[k*DATA_W +: DATA_W];
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0]     sclk_sync_r, ncs_sync_r, copi_sync_r;
    state_t                     state_r, state_n;
    logic [CNT_W-1:0]           cnt_r, cnt_n;
    logic [FRAME_W-1:0]         shift_r, shift_n;
    logic [DATA_W-1:0]          shadow_r, shadow_n;
    logic                       loaded_r, loaded_n;
    logic [NUM_REGS*DATA_W-1:0] regs_r, regs_n;
    logic [NUM_REGS-1:0]        strobe_r, strobe_n;
    logic                       err_r, err_n;
    logic                       cipo_r, cipo_n;
    logic                       oe_r;
    logic                       sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s, copi_s;
    logic [NUM_REGS-1:0]        wr_sel_s, rd_sel_s;

    // Pin synchronisers; reset values model an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= '0;
            ncs_sync_r  <= '1;
            copi_sync_r <= '0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], nCS};
            copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], COPI};
        end
    end

    assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-2] & ~sclk_sync_r[SYNC_STAGES-1];
    assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-2] & sclk_sync_r[SYNC_STAGES-1];
    assign ncs_rise_s  = ncs_sync_r[SYNC_STAGES-2] & ~ncs_sync_r[SYNC_STAGES-1];
    assign ncs_fall_s  = ~ncs_sync_r[SYNC_STAGES-2] & ncs_sync_r[SYNC_STAGES-1];
    assign copi_s      = copi_sync_r[SYNC_STAGES-1];

    // Complete frame holds {rw, addr, data}; during DATA's first fall the low bits hold {rw, addr}.
    assign wr_sel_s = addr_sel(shift_r[FRAME_W-2 -: ADDR_W]);
    assign rd_sel_s = addr_sel(shift_r[ADDR_W-1:0]);

    // Frame FSM next-state plus datapath next values; nCS edges take priority over SCLK edges.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        shift_n  = shift_r;
        shadow_n = shadow_r;
        loaded_n = loaded_r;
        regs_n   = regs_r;
        strobe_n = '0;
        err_n    = 1'b0;
        cipo_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ncs_fall_s) begin
                    state_n  = ST_CMD;
                    cnt_n    = '0;
                    shift_n  = '0;
                    shadow_n = '0;
                    loaded_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD, ST_DATA, ST_FULL, ST_OVER: begin
                if (ncs_rise_s) begin
                    state_n = ST_IDLE;
                    if (state_r == ST_FULL) begin
                        if (shift_r[FRAME_W-1]) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (wr_sel_s[k]) begin
                                    regs_n[k*DATA_W +: DATA_W] = shift_r[DATA_W-1:0];
                                end else begin
                                    regs_n[k*DATA_W +: DATA_W] = regs_r[k*DATA_W +: DATA_W];
                                end
                            end
                            strobe_n = wr_sel_s;
                        end else begin
                            strobe_n = '0;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    case (state_r)
                        ST_CMD: begin
                            shift_n = {shift_r[FRAME_W-2:0], copi_s};
                            cnt_n   = sat_inc(cnt_r);
                            if (cnt_n == CNT_CMD) begin
                                state_n = ST_DATA;
                            end else begin
                                state_n = ST_CMD;
                            end
                        end
                        ST_DATA: begin
                            shift_n = {shift_r[FRAME_W-2:0], copi_s};
                            cnt_n   = sat_inc(cnt_r);
                            if (cnt_n == CNT_FRAME) begin
                                state_n = ST_FULL;
                            end else begin
                                state_n = ST_DATA;
                            end
                        end
                        ST_FULL: begin
                            state_n = ST_OVER;
                            cnt_n   = sat_inc(cnt_r);
                        end
                        default: begin
                            state_n = state_r;
                        end
                    endcase
                end else if (sclk_fall_s) begin
                    if (state_r == ST_DATA) begin
                        if (!loaded_r) begin
                            shadow_n = read_mux(regs_r, rd_sel_s);
                            loaded_n = 1'b1;
                        end else begin
                            shadow_n = shadow_r << 1'b1;
                        end
                    end else if (state_r == ST_FULL) begin
                        shadow_n = shadow_r << 1'b1;
                    end else begin
                        shadow_n = shadow_r;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if ((state_n == ST_DATA) || (state_n == ST_FULL)) begin
            cipo_n = shadow_n[DATA_W-1];
        end else begin
            cipo_n = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            shift_r  <= '0;
            shadow_r <= '0;
            loaded_r <= 1'b0;
            regs_r   <= '0;
            strobe_r <= '0;
            err_r    <= 1'b0;
            cipo_r   <= 1'b0;
            oe_r     <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            shift_r  <= shift_n;
            shadow_r <= shadow_n;
            loaded_r <= loaded_n;
            regs_r   <= regs_n;
            strobe_r <= strobe_n;
            err_r    <= err_n;
            cipo_r   <= cipo_n;
            oe_r     <= ~ncs_sync_r[SYNC_STAGES-2];
        end
    end

    assign CIPO      = cipo_r;
    assign CIPO_oe   = oe_r;
    assign regs_flat = regs_r;
    assign wr_strobe = strobe_r;
    assign frame_err = err_r;

endmodule
